// File: rtl/counter_pkg.sv
// Shared definitions for the modulo up/down counter family: direction
// encodings, run/halt state type and the prescaler width helper.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic {
    ST_RUN,
    ST_HALT
  } state_t;

  // A prescaler that divides by P needs to hold values 0..P-1; never narrower than 1 bit.
  function automatic int prescale_width(input int prescale);
    return (prescale <= 2) ? 1 : $clog2(prescale);
  endfunction

endpackage

// File: rtl/updown_mod_counter_step_prescaler.sv
// Enable prescaler: emits a one-cycle step after PRESCALE enabled cycles.
// Clearing restarts the division; hold freezes it.
module step_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  input  logic hold,
  output logic step
);

  generate
    if (PRESCALE == 1) begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ reset;
      assign step = en & ~clr & ~hold;
    end else begin : g_div
      localparam int PW = prescale_width(PRESCALE);
      localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

      logic [PW-1:0] cnt_q;
      logic [PW-1:0] cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        step  = 1'b0;
        if (clr) begin
          cnt_d = '0;
        end else if (!hold && en) begin
          if (cnt_q == LAST) begin
            cnt_d = '0;
            step  = 1'b1;
          end else begin
            cnt_d = cnt_q + PW'(1);
          end
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/updown_mod_counter.sv
// Parametrised modulo up/down counter with load, prescaled enable,
// one-shot halt and a registered terminal-count pulse.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = (1 << WIDTH) - 1,
  parameter int RESET_VAL = MAX_COUNT,
  parameter int PRESCALE  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             one_shot,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             done
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  state_t           state_q, state_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  logic             step;
  logic             at_terminal;

  step_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .clr  (load),
    .hold (state_q == ST_HALT),
    .step (step)
  );

  assign at_terminal = (dir == DIR_UP) ? (count_q == MAX_V) : (count_q == '0);

  // Priority: load, then halt hold, then a prescaled step.
  always_comb begin
    count_d = count_q;
    state_d = state_q;
    tc_d    = 1'b0;
    done_d  = done_q;
    if (load) begin
      count_d = (load_val > MAX_V) ? MAX_V : load_val;
      state_d = ST_RUN;
      done_d  = 1'b0;
    end else if (state_q == ST_HALT) begin
      count_d = count_q;
    end else if (step) begin
      if (at_terminal) begin
        tc_d = 1'b1;
        if (one_shot) begin
          done_d  = 1'b1;
          state_d = ST_HALT;
        end else begin
          count_d = (dir == DIR_UP) ? '0 : MAX_V;
        end
      end else begin
        count_d = (dir == DIR_UP) ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= RST_V;
      state_q <= ST_RUN;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign done  = done_q;

endmodule
